ccip_mem_responder: RTL and testbench

CCIP_MEM_RESPONDER -- requirements
Module: ccip_mem_responder

---
 rtl/ccip_mem_responder_if.sv | 39 +++
 rtl/ccip_mem_responder.sv | 109 ++++++++++
 tb/tb_ccip_mem_responder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ccip_mem_responder_if.sv
// ccip_mem_responder_if: AFU-side request and response bundle for the CCI-P memory responder.
interface ccip_mem_responder_if;
    logic         afu_tx_rd_valid;
    logic [41:0]  afu_tx_rd_addr;
    logic [15:0]  afu_tx_rd_mdata;
    logic         spl_tx_rd_almostfull;
    logic         afu_tx_wr_valid;
    logic         afu_tx_wr_fence;
    logic [41:0]  afu_tx_wr_addr;
    logic [15:0]  afu_tx_wr_mdata;
    logic [511:0] afu_tx_data;
    logic         spl_tx_wr_almostfull;
    logic         spl_rx_rd_valid;
    logic [15:0]  spl_rx_rd_mdata;
    logic [511:0] spl_rx_data;
    logic         spl_rx_wr_valid;
    logic [15:0]  spl_rx_wr_mdata;
    logic         spl_rx_wr_fence;
    logic         rd_overflow;
    logic         wr_overflow;

    modport master (
        output afu_tx_rd_valid, afu_tx_rd_addr, afu_tx_rd_mdata,
        output afu_tx_wr_valid, afu_tx_wr_fence, afu_tx_wr_addr, afu_tx_wr_mdata, afu_tx_data,
        input  spl_tx_rd_almostfull, spl_tx_wr_almostfull,
        input  spl_rx_rd_valid, spl_rx_rd_mdata, spl_rx_data,
        input  spl_rx_wr_valid, spl_rx_wr_mdata, spl_rx_wr_fence,
        input  rd_overflow, wr_overflow
    );

    modport slave (
        input  afu_tx_rd_valid, afu_tx_rd_addr, afu_tx_rd_mdata,
        input  afu_tx_wr_valid, afu_tx_wr_fence, afu_tx_wr_addr, afu_tx_wr_mdata, afu_tx_data,
        output spl_tx_rd_almostfull, spl_tx_wr_almostfull,
        output spl_rx_rd_valid, spl_rx_rd_mdata, spl_rx_data,
        output spl_rx_wr_valid, spl_rx_wr_mdata, spl_rx_wr_fence,
        output rd_overflow, wr_overflow
    );
endinterface

// File: rtl/ccip_mem_responder.sv
// ccip_mem_responder: CCI-P memory model with in-order read/write queues, fixed read latency
// and fence completions.
module ccip_mem_responder #(
    parameter int MEM_AW     = 6,
    parameter int RD_LAT     = 4,
    parameter int QDEPTH     = 8,
    parameter int ALMFULL_TH = 6
) (
    input logic clk,
    input logic spl_reset,
    ccip_mem_responder_if.slave bus
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PL = RD_LAT;

    logic [511:0]       mem [2**MEM_AW];
    logic [16:0]        wq [QDEPTH];
    logic [MEM_AW+15:0] rq [QDEPTH];
    logic [PW-1:0]      wq_wp, wq_rp, rq_wp, rq_rp;
    logic [CW-1:0]      wq_cnt, rq_cnt;
    logic               wr_push, wr_pop, rd_push, rd_pop, rd_hold;
    logic               cmp_valid;
    logic [16:0]        cmp_entry;
    logic [MEM_AW-1:0]  wr_idx, rd_idx;
    logic [511:0]       rd_word;
    logic [PL-1:0]      pv;
    logic [15:0]        pm [PL];
    logic [511:0]       pd [PL];
    logic               unused;

    // Stall hook for the read pop stage; tied off in the design, forced only from a bench.
    assign rd_hold = 1'b0;
    assign unused  = ^{bus.afu_tx_rd_addr[41:MEM_AW], bus.afu_tx_wr_addr[41:MEM_AW]};

    assign wr_idx  = bus.afu_tx_wr_addr[MEM_AW-1:0];
    assign rd_idx  = rq[rq_rp][MEM_AW+15:16];
    assign wr_pop  = wq_cnt != '0;
    assign wr_push = bus.afu_tx_wr_valid && (int'(wq_cnt) != QDEPTH || wr_pop);
    assign rd_pop  = rq_cnt != '0 && !rd_hold;
    assign rd_push = bus.afu_tx_rd_valid && (int'(rq_cnt) != QDEPTH || rd_pop);
    // A write landing on the pop edge must be visible to the read popped at that edge.
    assign rd_word = (wr_push && !bus.afu_tx_wr_fence && wr_idx == rd_idx) ? bus.afu_tx_data : mem[rd_idx];

    assign bus.spl_rx_rd_valid = pv[PL-1];
    assign bus.spl_rx_rd_mdata = pm[PL-1];
    assign bus.spl_rx_data     = pd[PL-1];

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (int'(p) == QDEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (wr_push && !bus.afu_tx_wr_fence) mem[wr_idx] <= bus.afu_tx_data;
        if (wr_push) wq[wq_wp] <= {bus.afu_tx_wr_mdata, bus.afu_tx_wr_fence};
        if (rd_push) rq[rq_wp] <= {bus.afu_tx_rd_addr[MEM_AW-1:0], bus.afu_tx_rd_mdata};
    end

    always_ff @(posedge clk or posedge spl_reset) begin
        if (spl_reset) begin
            wq_wp                    <= '0;
            wq_rp                    <= '0;
            wq_cnt                   <= '0;
            rq_wp                    <= '0;
            rq_rp                    <= '0;
            rq_cnt                   <= '0;
            cmp_valid                <= 1'b0;
            cmp_entry                <= '0;
            pv                       <= '0;
            bus.spl_rx_wr_valid      <= 1'b0;
            bus.spl_rx_wr_mdata      <= '0;
            bus.spl_rx_wr_fence      <= 1'b0;
            bus.spl_tx_wr_almostfull <= 1'b0;
            bus.spl_tx_rd_almostfull <= 1'b0;
            bus.wr_overflow          <= 1'b0;
            bus.rd_overflow          <= 1'b0;
            for (int i = 0; i < PL; i++) begin
                pm[i] <= '0;
                pd[i] <= '0;
            end
        end else begin
            if (wr_push) wq_wp <= inc(wq_wp);
            if (wr_pop) wq_rp <= inc(wq_rp);
            wq_cnt                   <= wq_cnt + CW'(wr_push) - CW'(wr_pop);
            bus.wr_overflow          <= bus.wr_overflow | (bus.afu_tx_wr_valid && !wr_push);
            bus.spl_tx_wr_almostfull <= int'(wq_cnt) >= ALMFULL_TH;
            cmp_valid                <= wr_pop;
            if (wr_pop) cmp_entry <= wq[wq_rp];
            bus.spl_rx_wr_valid      <= cmp_valid;
            bus.spl_rx_wr_mdata      <= cmp_entry[16:1];
            bus.spl_rx_wr_fence      <= cmp_valid & cmp_entry[0];
            if (rd_push) rq_wp <= inc(rq_wp);
            if (rd_pop) rq_rp <= inc(rq_rp);
            rq_cnt                   <= rq_cnt + CW'(rd_push) - CW'(rd_pop);
            bus.rd_overflow          <= bus.rd_overflow | (bus.afu_tx_rd_valid && !rd_push);
            bus.spl_tx_rd_almostfull <= int'(rq_cnt) >= ALMFULL_TH;
            pv[0]                    <= rd_pop;
            if (rd_pop) begin
                pm[0] <= rq[rq_rp][15:0];
                pd[0] <= rd_word;
            end
            for (int i = 1; i < PL; i++) begin
                pv[i] <= pv[i-1];
                pm[i] <= pm[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end
endmodule

// File: tb/tb_ccip_mem_responder.sv
// tb_ccip_mem_responder: directed stimulus with a queue scoreboard and an independent response monitor.
module tb_ccip_mem_responder;
    localparam int RD_LAT = 4;

    typedef struct {
        logic [15:0]  m;
        logic         f;
        logic [511:0] d;
        int           t;
    } exp_t;

    logic clk = 1'b0;
    logic spl_reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t wq_e[$];
    exp_t rq_e[$];
    logic [511:0] model [64];

    ccip_mem_responder_if bus();

    ccip_mem_responder #(.MEM_AW(6), .RD_LAT(RD_LAT), .QDEPTH(8), .ALMFULL_TH(6)) dut (
        .clk(clk),
        .spl_reset(spl_reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    function automatic logic [511:0] pat(input int n);
        return {16{32'hC0DE_0000 + 32'(n)}};
    endfunction

    task automatic next();
        @(negedge clk);
        bus.afu_tx_rd_valid = 1'b0;
        bus.afu_tx_wr_valid = 1'b0;
        bus.afu_tx_wr_fence = 1'b0;
    endtask

    task automatic set_wr(input logic [41:0] a, input logic [15:0] m, input logic [511:0] d, input logic f);
        exp_t e;
        bus.afu_tx_wr_valid = 1'b1;
        bus.afu_tx_wr_addr  = a;
        bus.afu_tx_wr_mdata = m;
        bus.afu_tx_data     = d;
        bus.afu_tx_wr_fence = f;
        if (!f) model[a[5:0]] = d;
        e.m = m; e.f = f; e.d = '0; e.t = cyc + 3;
        wq_e.push_back(e);
    endtask

    task automatic set_rd(input logic [41:0] a, input logic [15:0] m, input logic [511:0] d, input bit timed, input bit expect_rsp);
        exp_t e;
        bus.afu_tx_rd_valid = 1'b1;
        bus.afu_tx_rd_addr  = a;
        bus.afu_tx_rd_mdata = m;
        e.m = m; e.f = 1'b0; e.d = d; e.t = timed ? cyc + 1 + RD_LAT : -1;
        if (expect_rsp) rq_e.push_back(e);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rd_valid"}, 512'(bus.spl_rx_rd_valid), '0);
        chk({tag, "_wr_valid"}, 512'(bus.spl_rx_wr_valid), '0);
        chk({tag, "_almfull"}, 512'({bus.spl_tx_rd_almostfull, bus.spl_tx_wr_almostfull}), '0);
        chk({tag, "_overflow"}, 512'({bus.rd_overflow, bus.wr_overflow}), '0);
        chk({tag, "_mdata"}, 512'({bus.spl_rx_rd_mdata, bus.spl_rx_wr_mdata, bus.spl_rx_wr_fence}), '0);
        chk({tag, "_data"}, bus.spl_rx_data, '0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.spl_rx_wr_valid) begin
            if (wq_e.size() == 0) chk("wr_unexpected", 512'(bus.spl_rx_wr_mdata), 512'h0_dead);
            else begin
                e = wq_e.pop_front();
                chk("wr_mdata", 512'(bus.spl_rx_wr_mdata), 512'(e.m));
                chk("wr_fence", 512'(bus.spl_rx_wr_fence), 512'(e.f));
                chk("wr_cycle", 512'(cyc), 512'(e.t));
            end
        end
        if (bus.spl_rx_rd_valid) begin
            if (rq_e.size() == 0) chk("rd_unexpected", 512'(bus.spl_rx_rd_mdata), 512'h0_dead);
            else begin
                e = rq_e.pop_front();
                chk("rd_mdata", 512'(bus.spl_rx_rd_mdata), 512'(e.m));
                chk("rd_data", bus.spl_rx_data, e.d);
                if (e.t >= 0) chk("rd_cycle", 512'(cyc), 512'(e.t));
            end
        end
    end

    initial begin
        bus.afu_tx_rd_valid = 1'b0;
        bus.afu_tx_rd_addr  = '0;
        bus.afu_tx_rd_mdata = '0;
        bus.afu_tx_wr_valid = 1'b0;
        bus.afu_tx_wr_fence = 1'b0;
        bus.afu_tx_wr_addr  = '0;
        bus.afu_tx_wr_mdata = '0;
        bus.afu_tx_data     = '0;
        repeat (3) next();
        chk_idle_outputs("reset");
        spl_reset = 1'b0;
        repeat (2) next();

        // write line 3 then read it back
        set_wr(42'd3, 16'h11, {64{8'hA5}}, 1'b0);
        next(); set_rd(42'd3, 16'h22, {64{8'hA5}}, 1'b1, 1'b1);
        repeat (8) next();

        // two writes and a fence complete on consecutive cycles, fence last
        set_wr(42'd5, 16'h5, pat(5), 1'b0);
        next(); set_wr(42'd6, 16'h6, pat(6), 1'b0);
        next(); set_wr(42'd5, 16'h7, pat(99), 1'b1);
        repeat (4) next();
        set_rd(42'd5, 16'h55, pat(5), 1'b1, 1'b1);
        next(); set_rd(42'd6, 16'h66, pat(6), 1'b1, 1'b1);
        repeat (8) next();

        // fill lines 0..9, then 10 back-to-back reads with no back-pressure
        for (int i = 0; i < 10; i++) begin
            set_wr(42'(i), 16'(16'h40 + i), pat(100 + i), 1'b0);
            next();
        end
        repeat (4) next();
        for (int i = 0; i < 10; i++) begin
            set_rd(42'(i), 16'(16'h100 + i), pat(100 + i), 1'b1, 1'b1);
            next();
            chk("b2b_almfull", 512'(bus.spl_tx_rd_almostfull), '0);
            chk("b2b_overflow", 512'(bus.rd_overflow), '0);
        end
        repeat (8) next();

        // same-cycle write and read of 0x40, which aliases line 0
        set_wr(42'h40, 16'h80, pat(200), 1'b0);
        set_rd(42'h40, 16'h81, pat(200), 1'b1, 1'b1);
        next();
        // write arriving on the read's pop edge
        set_rd(42'd7, 16'h82, pat(201), 1'b1, 1'b1);
        next(); set_wr(42'd7, 16'h83, pat(201), 1'b0);
        repeat (8) next();

        // stall the pop stage: almostfull, then overflow on the 9th push
        force dut.rd_hold = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            set_rd(42'(k - 1), 16'(16'h200 + k), (k == 8) ? pat(201) : (k == 1) ? pat(200) : pat(99 + k), 1'b0, k <= 8);
            next();
            chk("hold_almfull", 512'(bus.spl_tx_rd_almostfull), 512'(k >= 7));
            chk("hold_overflow", 512'(bus.rd_overflow), 512'(k == 9));
        end
        repeat (3) next();
        chk("overflow_sticky", 512'(bus.rd_overflow), 512'd1);
        release dut.rd_hold;
        repeat (16) next();
        chk("overflow_after_drain", 512'(bus.rd_overflow), 512'd1);
        chk("almfull_after_drain", 512'(bus.spl_tx_rd_almostfull), '0);

        // reset while four reads are in flight: none may come back
        for (int i = 0; i < 4; i++) begin
            set_rd(42'(i), 16'(16'h300 + i), '0, 1'b0, 1'b0);
            next();
        end
        spl_reset = 1'b1;
        #1;
        chk_idle_outputs("midreset");
        repeat (3) next();
        chk_idle_outputs("midreset_hold");
        spl_reset = 1'b0;
        repeat (12) next();
        set_wr(42'd9, 16'h90, pat(300), 1'b0);
        next(); set_rd(42'd9, 16'h91, pat(300), 1'b1, 1'b1);
        next();

        for (int i = 0; i < 200 && (wq_e.size() != 0 || rq_e.size() != 0); i++) next();
        chk("scoreboard_drained", 512'(wq_e.size() + rq_e.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
